mix_columns_engine: RTL and testbench
=====================================

# mix_columns_engine

Sequential, parametrised AES MixColumns / InvMixColumns engine for the round datapath. It accepts one 128-bit state per valid/ready handshake and a per-block direction bit. It transforms COLS_PER_CYCLE columns per clock over 4/COLS_PER_CYCLE cycles, then holds the result until the consumer accepts it. It replaces the purely combinational inverse-only column mixer and serves both the encrypt and decrypt round loops, trading area for latency.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- in_valid  input  1  in_state / in_inverse are valid.
- in_ready  output  1  engine can accept a block.
- in_state  input  128  AES state, column c at bits [127-32c -: 32], row 0 byte is the MSB of each column (FIPS-197 order).
- in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled at acceptance.
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  128  transformed state, same byte ordering as in_state.
- busy  output  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_state into the working register, latch in_inverse into the mode register, clear the column counter and go to BUSY.
- BUSY:
  - Each cycle, columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 are replaced in place by their transform.
  - col_cnt advances by COLS_PER_CYCLE.
  - After the cycle that transforms column 3, go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE.
  - out_state is stable while out_valid is high and out_ready is low.
- Transform of column (a0,a1,a2,a3) to (b0..b3), all arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1:
  - Forward rows: 02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02.
  - Inverse rows: 0e 0b 0d 09 / 09 0e 0b 0d / 0d 09 0e 0b / 0b 0d 09 0e.
- xtime(x) = (x<<1)[7:0] ^ (x[7] ? 8'h1b : 8'h00).
- Higher constants are built from xtime and XOR: 03=02^01, 09=08^01, 0b=08^02^01, 0d=08^04^01, 0e=08^04^02.
- All byte math is 8 bits wide, with no carries between bytes.
- Column counter is 2 bits. With COLS_PER_CYCLE=4 it is unused and BUSY lasts one cycle.
- in_ready is 0 in BUSY and DONE. in_valid there is ignored and must be held by the producer.
- out_state always drives the working register. Its value outside DONE is don't-care for consumers, but it is deterministic and equals the register contents.
- Mode is fixed per block; changing in_inverse after acceptance has no effect.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, busy=0, out_state=128'h0, col_cnt=0, mode=0.
- Reset asserted mid-block aborts the block. No partial result is ever presented.
- Let N = 4/COLS_PER_CYCLE.
- Acceptance at edge k (in_valid & in_ready sampled high). BUSY covers cycles k+1 .. k+N. out_valid rises after edge k+N.
- With out_ready held high: DONE lasts one cycle and in_ready returns after edge k+N+1.
- Throughput: one block per N+2 cycles with no back-pressure.
- in_ready and out_valid are never high in the same cycle.
- out_valid is registered. in_ready is decoded from the state register only, with no combinational path from in_valid or out_ready.

## Test plan
- Forward, COLS_PER_CYCLE=1:
  - Stimulus: columns db135345, f20a225c, 01010101, c6c6c6c6.
  - Required out_state: 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
  - out_valid rises exactly 4 cycles after acceptance.
- Inverse, COLS_PER_CYCLE=2:
  - Stimulus: 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8.
  - Required out_state: db135345 f20a225c d4d4d4d5 2d26314c.
  - out_valid rises exactly 2 cycles after acceptance.
- Round trip, COLS_PER_CYCLE=4:
  - Stimulus: 1000 random states, each sent forward and the result fed back inverse.
  - Required: every original is recovered. Each block latency is 1 cycle and each block occupies 3 cycles with out_ready high.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid stays high with a new block.
  - Required: out_state stable, in_ready=0, second block not accepted until the cycle after out_ready=1.
- Async reset:
  - Stimulus: assert rst_n=0 in BUSY after column 1 (COLS_PER_CYCLE=1).
  - Required: out_valid=0, busy=0, in_ready=1 and out_state=0 immediately, without a clock edge. The next block completes correctly.
- Mode latch:
  - Stimulus: toggle in_inverse every cycle during BUSY.
  - Required: result matches the mode sampled at acceptance.

Source files
------------

// File: rtl/mix_columns_engine_if.sv
// Handshake bundle between a round datapath and mix_columns_engine.
// slave is the engine side, master the producer/consumer side.
interface mix_columns_engine_if;
  localparam int unsigned STATE_W = 128;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               in_inverse;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               busy;

  modport slave (
    input  in_valid, in_state, in_inverse, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, in_inverse, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns engine: COLS_PER_CYCLE columns per
// clock, in place in a working register, result held until the consumer accepts.
module mix_columns_engine #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_engine_if.slave bus
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned CNT_W   = 2;
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0]   col_idx;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Multiply by 02 in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the circulant matrix; p/q/r/s are the row coefficients
  // applied to a[i], a[i+1], a[i+2], a[i+3] for output byte i.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  p  [4];
    logic [7:0]  q  [4];
    logic [7:0]  r  [4];
    logic [7:0]  s  [4];
    logic [31:0] res;
    logic [1:0]  i1, i2, i3;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      if (inv) begin
        p[i] = x8[i] ^ x4[i] ^ x2[i];
        q[i] = x8[i] ^ x2[i] ^ a[i];
        r[i] = x8[i] ^ x4[i] ^ a[i];
        s[i] = x8[i] ^ a[i];
      end else begin
        p[i] = x2[i];
        q[i] = x2[i] ^ a[i];
        r[i] = a[i];
        s[i] = a[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      i1 = 2'(i + 1);
      i2 = 2'(i + 2);
      i3 = 2'(i + 3);
      res[31-8*i -: 8] = p[i] ^ q[i1] ^ r[i2] ^ s[i3];
    end
    return res;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    mode_d    = mode_q;
    col_cnt_d = col_cnt_q;
    col_idx   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d    = bus.in_state;
          mode_d    = bus.in_inverse;
          col_cnt_d = '0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // Column c lives at bits [(3-c)*32 +: 32]; for 2-bit c, 3-c == ~c.
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          col_idx = col_cnt_q + CNT_W'(j);
          work_d[{~col_idx, 5'd0} +: COL_W] = mix_col(work_q[{~col_idx, 5'd0} +: COL_W], mode_q);
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      mode_q      <= 1'b0;
      col_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      col_cnt_q   <= col_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_state = work_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_engine;

  localparam logic [127:0] FWD_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN   = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] INV_OUT  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic         v_in_valid  [3];
  logic [127:0] v_in_state  [3];
  logic         v_in_inv    [3];
  logic         v_out_ready [3];
  logic         w_in_ready  [3];
  logic         w_out_valid [3];
  logic         w_busy      [3];
  logic [127:0] w_out_state [3];

  mix_columns_engine_if if1 ();
  mix_columns_engine_if if2 ();
  mix_columns_engine_if if4 ();

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  assign if1.in_valid   = v_in_valid[0];
  assign if1.in_state   = v_in_state[0];
  assign if1.in_inverse = v_in_inv[0];
  assign if1.out_ready  = v_out_ready[0];
  assign if2.in_valid   = v_in_valid[1];
  assign if2.in_state   = v_in_state[1];
  assign if2.in_inverse = v_in_inv[1];
  assign if2.out_ready  = v_out_ready[1];
  assign if4.in_valid   = v_in_valid[2];
  assign if4.in_state   = v_in_state[2];
  assign if4.in_inverse = v_in_inv[2];
  assign if4.out_ready  = v_out_ready[2];

  assign w_in_ready[0]  = if1.in_ready;
  assign w_out_valid[0] = if1.out_valid;
  assign w_busy[0]      = if1.busy;
  assign w_out_state[0] = if1.out_state;
  assign w_in_ready[1]  = if2.in_ready;
  assign w_out_valid[1] = if2.out_valid;
  assign w_busy[1]      = if2.busy;
  assign w_out_state[1] = if2.out_state;
  assign w_in_ready[2]  = if4.in_ready;
  assign w_out_valid[2] = if4.out_valid;
  assign w_busy[2]      = if4.busy;
  assign w_out_state[2] = if4.out_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if ((w_in_ready[d] & w_out_valid[d]) !== 1'b0) begin
          n_bad++;
          $display("FAIL overlap dut%0d: in_ready=%b out_valid=%b, required not both 1", d, w_in_ready[d], w_out_valid[d]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one block with out_ready low, wait for out_valid, capture, then accept.
  task automatic run_block(input int d, input logic [127:0] st, input logic inv, input bit toggle,
                           output logic [127:0] res, output int lat);
    int guard;
    guard = 0;
    while (!w_in_ready[d] && guard < 50) begin
      step();
      guard++;
    end
    v_in_state[d]  = st;
    v_in_inv[d]    = inv;
    v_in_valid[d]  = 1'b1;
    v_out_ready[d] = 1'b0;
    step();
    v_in_valid[d] = 1'b0;
    lat = 0;
    while (!w_out_valid[d] && lat < 50) begin
      if (toggle) v_in_inv[d] = ~v_in_inv[d];
      step();
      lat++;
    end
    res = w_out_state[d];
    v_out_ready[d] = 1'b1;
    step();
    v_out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_cmp += 4;
      if (w_in_ready[d] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready dut%0d: got %b, required 1", d, w_in_ready[d]); end
      if (w_out_valid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid dut%0d: got %b, required 0", d, w_out_valid[d]); end
      if (w_busy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b, required 0", d, w_busy[d]); end
      if (w_out_state[d] !== 128'h0) begin n_bad++; $display("FAIL reset_out_state dut%0d: got %h, required 0", d, w_out_state[d]); end
    end
  endtask

  task automatic test_forward_c1();
    logic [127:0] res;
    int lat;
    run_block(0, FWD_IN, 1'b0, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== FWD_OUT) begin n_bad++; $display("FAIL fwd_c1 state: got %h, required %h", res, FWD_OUT); end
    if (lat !== 4) begin n_bad++; $display("FAIL fwd_c1 latency: got %0d, required 4", lat); end
  endtask

  task automatic test_inverse_c2();
    logic [127:0] res;
    int lat;
    run_block(1, INV_IN, 1'b1, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== INV_OUT) begin n_bad++; $display("FAIL inv_c2 state: got %h, required %h", res, INV_OUT); end
    if (lat !== 2) begin n_bad++; $display("FAIL inv_c2 latency: got %0d, required 2", lat); end
  endtask

  task automatic test_fips_c4();
    logic [127:0] res;
    int lat;
    run_block(2, FIPS_IN, 1'b0, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== FIPS_OUT) begin n_bad++; $display("FAIL fips_fwd_c4 state: got %h, required %h", res, FIPS_OUT); end
    if (lat !== 1) begin n_bad++; $display("FAIL fips_fwd_c4 latency: got %0d, required 1", lat); end
    run_block(2, FIPS_OUT, 1'b1, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== FIPS_IN) begin n_bad++; $display("FAIL fips_inv_c4 state: got %h, required %h", res, FIPS_IN); end
    if (lat !== 1) begin n_bad++; $display("FAIL fips_inv_c4 latency: got %0d, required 1", lat); end
    run_block(1, FIPS_IN, 1'b0, 1'b0, res, lat);
    n_cmp++;
    if (res !== FIPS_OUT) begin n_bad++; $display("FAIL fips_fwd_c2 state: got %h, required %h", res, FIPS_OUT); end
  endtask

  task automatic test_round_trip_c4();
    logic [127:0] orig, mid, back;
    int lat_f, lat_i, bad_here;
    bad_here = 0;
    for (int n = 0; n < 1000; n++) begin
      orig = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(2, orig, 1'b0, 1'b0, mid, lat_f);
      run_block(2, mid, 1'b1, 1'b0, back, lat_i);
      n_cmp += 2;
      if (back !== orig) begin
        n_bad++;
        if (bad_here < 5) $display("FAIL round_trip #%0d: got %h, required %h", n, back, orig);
        bad_here++;
      end
      if (lat_f !== 1 || lat_i !== 1) begin
        n_bad++;
        if (bad_here < 5) $display("FAIL round_trip_latency #%0d: got %0d/%0d, required 1/1", n, lat_f, lat_i);
        bad_here++;
      end
    end
  endtask

  // in_valid and out_ready held high: acceptances must be exactly period apart.
  task automatic test_back_to_back(input int d, input int period);
    int acc [3];
    int n_acc, guard;
    n_acc = 0;
    guard = 0;
    while (!w_in_ready[d] && guard < 50) begin step(); guard++; end
    v_in_state[d]  = FWD_IN;
    v_in_inv[d]    = 1'b0;
    v_out_ready[d] = 1'b1;
    v_in_valid[d]  = 1'b1;
    for (int c = 0; c < 3 * period; c++) begin
      if (w_in_ready[d] && n_acc < 3) begin
        acc[n_acc] = c;
        n_acc++;
      end
      step();
    end
    v_in_valid[d] = 1'b0;
    guard = 0;
    while ((w_busy[d] || !w_in_ready[d]) && guard < 50) begin step(); guard++; end
    v_out_ready[d] = 1'b0;
    n_cmp += 2;
    if (n_acc !== 3) begin
      n_bad++;
      $display("FAIL b2b_count dut%0d: got %0d acceptances, required 3", d, n_acc);
    end else if (acc[1] - acc[0] !== period || acc[2] - acc[1] !== period) begin
      n_bad++;
      $display("FAIL b2b_period dut%0d: got %0d/%0d, required %0d", d, acc[1] - acc[0], acc[2] - acc[1], period);
    end
    if (w_out_state[d] !== FWD_OUT) begin
      n_bad++;
      $display("FAIL b2b_state dut%0d: got %h, required %h", d, w_out_state[d], FWD_OUT);
    end
  endtask

  task automatic test_back_pressure();
    int guard;
    guard = 0;
    while (!w_in_ready[1] && guard < 50) begin step(); guard++; end
    v_in_state[1]  = FIPS_IN;
    v_in_inv[1]    = 1'b0;
    v_out_ready[1] = 1'b0;
    v_in_valid[1]  = 1'b1;
    step();
    v_in_state[1] = FWD_IN;
    guard = 0;
    while (!w_out_valid[1] && guard < 50) begin step(); guard++; end
    for (int c = 0; c < 10; c++) begin
      n_cmp += 3;
      if (w_out_state[1] !== FIPS_OUT) begin n_bad++; $display("FAIL bp_state cyc%0d: got %h, required %h", c, w_out_state[1], FIPS_OUT); end
      if (w_in_ready[1] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc%0d: got %b, required 0", c, w_in_ready[1]); end
      if (w_out_valid[1] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid cyc%0d: got %b, required 1", c, w_out_valid[1]); end
      step();
    end
    v_out_ready[1] = 1'b1;
    step();
    v_out_ready[1] = 1'b0;
    n_cmp += 2;
    if (w_busy[1] !== 1'b0) begin n_bad++; $display("FAIL bp_early_accept: busy got %b, required 0", w_busy[1]); end
    if (w_in_ready[1] !== 1'b1) begin n_bad++; $display("FAIL bp_release in_ready: got %b, required 1", w_in_ready[1]); end
    step();
    v_in_valid[1] = 1'b0;
    n_cmp++;
    if (w_busy[1] !== 1'b1) begin n_bad++; $display("FAIL bp_second_accept: busy got %b, required 1", w_busy[1]); end
    guard = 0;
    while (!w_out_valid[1] && guard < 50) begin step(); guard++; end
    n_cmp++;
    if (w_out_state[1] !== FWD_OUT) begin n_bad++; $display("FAIL bp_second_state: got %h, required %h", w_out_state[1], FWD_OUT); end
    v_out_ready[1] = 1'b1;
    step();
    v_out_ready[1] = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [127:0] res;
    int lat, guard;
    guard = 0;
    while (!w_in_ready[0] && guard < 50) begin step(); guard++; end
    v_in_state[0] = FWD_IN;
    v_in_inv[0]   = 1'b0;
    v_in_valid[0] = 1'b1;
    step();
    v_in_valid[0] = 1'b0;
    step();
    step();
    n_cmp++;
    if (w_busy[0] !== 1'b1) begin n_bad++; $display("FAIL areset_pre busy: got %b, required 1", w_busy[0]); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (w_out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %b, required 0", w_out_valid[0]); end
    if (w_busy[0] !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b, required 0", w_busy[0]); end
    if (w_in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b, required 1", w_in_ready[0]); end
    if (w_out_state[0] !== 128'h0) begin n_bad++; $display("FAIL areset_out_state: got %h, required 0", w_out_state[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_block(0, FWD_IN, 1'b0, 1'b0, res, lat);
    n_cmp++;
    if (res !== FWD_OUT) begin n_bad++; $display("FAIL areset_next_block: got %h, required %h", res, FWD_OUT); end
  endtask

  task automatic test_mode_latch();
    logic [127:0] res;
    int lat;
    run_block(0, FWD_IN, 1'b0, 1'b1, res, lat);
    n_cmp++;
    if (res !== FWD_OUT) begin n_bad++; $display("FAIL mode_latch_fwd: got %h, required %h", res, FWD_OUT); end
    run_block(0, INV_IN, 1'b1, 1'b1, res, lat);
    n_cmp++;
    if (res !== INV_OUT) begin n_bad++; $display("FAIL mode_latch_inv: got %h, required %h", res, INV_OUT); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      v_in_valid[d]  = 1'b0;
      v_in_state[d]  = '0;
      v_in_inv[d]    = 1'b0;
      v_out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_forward_c1();
    test_inverse_c2();
    test_fips_c4();
    test_round_trip_c4();
    test_back_to_back(2, 3);
    test_back_to_back(0, 6);
    test_back_pressure();
    test_async_reset();
    test_mode_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
